// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared constants and types for the data memory
package data_mem_pkg;

  typedef logic [31:0] word_t;

  // Upper half-word that marks the memory-mapped I/O region
  localparam logic [15:0] IO_REGION_HI = 16'hFFFF;

  localparam word_t DEFAULT_OUT_ADDR = 32'hFFFF0000;
  localparam word_t DEFAULT_IN_ADDR  = 32'hFFFF0001;

endpackage

// File: rtl/data_mem_ram.sv
// rtl/data_mem_ram.sv - DEPTH x 32 RAM, asynchronous read, synchronous write
module data_mem_ram
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  word_t         wd_i,
  output word_t         rd_o
);

  // Contents are deliberately not reset; software must write before reading
  word_t mem_q [DEPTH];

  // Commit the write on the rising edge; no read bypass
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wd_i;
    end
  end

  assign rd_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-addressed data memory with output/input I/O ports (option: DATAMEM_IN_SYNC_EN)
module data_mem
  import data_mem_pkg::*;
#(
  parameter int    DEPTH    = 256,
  parameter word_t OUT_ADDR = DEFAULT_OUT_ADDR,
  parameter word_t IN_ADDR  = DEFAULT_IN_ADDR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we,
  input  word_t addr,
  input  word_t wd,
  input  word_t entradas,
  output word_t rd,
  output word_t salidas
);

  localparam int AW = $clog2(DEPTH);

  logic  is_io;
  logic  ram_we;
  word_t ram_rd;
  word_t salidas_q;
  word_t salidas_d;
  word_t in_val;

  // Anything outside the I/O region is RAM; upper address bits simply alias
  assign is_io  = (addr[31:16] == IO_REGION_HI);
  assign ram_we = we & ~is_io;

  data_mem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we_i  (ram_we),
    .idx_i (addr[AW-1:0]),
    .wd_i  (wd),
    .rd_o  (ram_rd)
  );

  // Output port takes new data only on a write aimed exactly at OUT_ADDR
  always_comb begin
    salidas_d = salidas_q;
    if (we && (addr == OUT_ADDR)) begin
      salidas_d = wd;
    end
  end

  // Output port register; reset wins over any concurrent write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      salidas_q <= '0;
    end else begin
      salidas_q <= salidas_d;
    end
  end

  assign salidas = salidas_q;

`ifdef DATAMEM_IN_SYNC_EN
  word_t sync1_q;
  word_t sync2_q;

  // Two-flop synchroniser for the asynchronous external input pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= entradas;
      sync2_q <= sync1_q;
    end
  end

  assign in_val = sync2_q;
`else
  assign in_val = entradas;
`endif

  // Combinational read mux; unmapped I/O addresses read as zero
  always_comb begin
    rd = '0;
    if (!is_io) begin
      rd = ram_rd;
    end else if (addr == OUT_ADDR) begin
      rd = salidas_q;
    end else if (addr == IN_ADDR) begin
      rd = in_val;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - self-checking bench for data_mem
module tb_data_mem;

  localparam int DEPTH = 256;
  localparam logic [31:0] OUT_A = 32'hFFFF0000;
  localparam logic [31:0] IN_A  = 32'hFFFF0001;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] entradas;
  logic [31:0] rd;
  logic [31:0] salidas;

  sb_t sb_q[$];
  sb_t e;
  int  tests_run;
  int  tests_failed;

  data_mem #(
    .DEPTH    (DEPTH),
    .OUT_ADDR (OUT_A),
    .IN_ADDR  (IN_A)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .entradas (entradas),
    .rd       (rd),
    .salidas  (salidas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single write: present at mid-cycle, commit at the next edge, then drop we
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (salidas !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_salidas: got %h expected %h", salidas, 32'h0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ram_signed();
    int vals[7] = '{-100, -50, -1, 0, 1, 50, 100};
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{$sformatf("ram_signed[%0d]", 100 + i), 32'(vals[i])});
      wr(32'(100 + i), 32'(vals[i]));
    end
    for (int i = 0; i < 7; i++) begin
      addr = 32'(100 + i);
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (rd !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
      end
    end
  endtask

  task automatic test_out_port();
    wr(32'd0, 32'hA5A5);
    wr(OUT_A, 32'd500);
    tests_run++;
    if (salidas !== 32'h1F4) begin
      tests_failed++;
      $display("FAIL out_salidas: got %h expected %h", salidas, 32'h1F4);
    end
    sb_q.push_back('{"out_readback", 32'h1F4});
    sb_q.push_back('{"out_ram0_untouched", 32'hA5A5});
    addr = OUT_A;
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (rd !== e.exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
    end
    addr = 32'd0;
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (rd !== e.exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (salidas !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset_salidas: got %h expected %h", salidas, 32'h0);
    end
    // writes while held in reset: port ignores it, RAM still commits
    wr(OUT_A, 32'h77);
    tests_run++;
    if (salidas !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_write_ignored: got %h expected %h", salidas, 32'h0);
    end
    sb_q.push_back('{"ram_write_in_reset", 32'h5A5A});
    wr(32'd50, 32'h5A5A);
    #2;
    rst_n = 1'b1;
    sb_q.push_back('{"ram100_after_reset", 32'hFFFFFF9C});
    addr = 32'd50;
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (rd !== e.exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
    end
    addr = 32'd100;
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (rd !== e.exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
    end
  endtask

  task automatic test_in_port();
    @(posedge clk);
    #1;
    entradas = 32'hCAFE;
    addr     = IN_A;
    #1;
`ifdef DATAMEM_IN_SYNC_EN
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL in_sync_edge0: got %h expected %h", rd, 32'h0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL in_sync_edge1: got %h expected %h", rd, 32'h0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (rd !== 32'hCAFE) begin
      tests_failed++;
      $display("FAIL in_sync_edge2: got %h expected %h", rd, 32'hCAFE);
    end
`else
    tests_run++;
    if (rd !== 32'hCAFE) begin
      tests_failed++;
      $display("FAIL in_comb: got %h expected %h", rd, 32'hCAFE);
    end
    entradas = 32'h1234_5678;
    #1;
    tests_run++;
    if (rd !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL in_comb_follow: got %h expected %h", rd, 32'h1234_5678);
    end
`endif
  endtask

  task automatic test_alias();
    logic [31:0] ra[3] = '{32'(5 + DEPTH), 32'd6, 32'h0001_0005};
    wr(32'd5, 32'd7);
    wr(32'(DEPTH + 6), 32'd7);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{$sformatf("alias_%h", ra[i]), 32'd7});
    end
    for (int i = 0; i < 3; i++) begin
      addr = ra[i];
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (rd !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
      end
    end
  endtask

  task automatic test_io_misc();
    wr(32'd1, 32'h1111);
    wr(32'd2, 32'h2222);
    wr(OUT_A, 32'h00C0FFEE);
    addr = 32'hFFFF0002;
    #1;
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL unmapped_io_read: got %h expected %h", rd, 32'h0);
    end
    wr(IN_A, 32'hDEAD_BEEF);
    wr(32'hFFFF0002, 32'hBAD0_BAD0);
    tests_run++;
    if (salidas !== 32'h00C0FFEE) begin
      tests_failed++;
      $display("FAIL in_write_salidas: got %h expected %h", salidas, 32'h00C0FFEE);
    end
    sb_q.push_back('{"io_write_ram1", 32'h1111});
    sb_q.push_back('{"io_write_ram2", 32'h2222});
    for (int i = 1; i <= 2; i++) begin
      addr = 32'(i);
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (rd !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    wr(32'd10, 32'h11);
    sb_q.push_back('{"same_cycle_old", 32'h11});
    sb_q.push_back('{"same_cycle_new", 32'h22});
    addr = 32'd10;
    wd   = 32'h22;
    we   = 1'b1;
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (rd !== e.exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    e = sb_q.pop_front();
    tests_run++;
    if (rd !== e.exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", e.name, rd, e.exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    we           = 1'b0;
    addr         = '0;
    wd           = '0;
    entradas     = '0;
    test_reset();
    test_ram_signed();
    test_out_port();
    test_async_reset();
    test_in_port();
    test_alias();
    test_io_misc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
